// File: rtl/cr_result_reader.sv
// -----------------------------------------------------------------------------
// cr_result_reader
//
// Drains correlated-randomness result words from the single-port result RAM
// and serializes each word, most-significant byte first, into a byte stream
// for the UART transmitter. A drain covers n_words consecutive RAM entries
// starting at base_addr; the address wraps modulo the RAM depth.
//
// Ports
//   clk          clock
//   rst_n        synchronous, active-low reset
//   start_i      one-cycle pulse launching a drain (ignored while busy)
//   base_addr_i  first RAM address, sampled on start_i
//   n_words_i    number of words to send (0..2^ADDR_W), sampled on start_i
//   ram_addr_o   RAM read address (only meaningful while busy_o=1)
//   ram_dout_i   RAM read data, valid RD_LAT cycles after the address
//   tx_data_o    byte to the transmitter
//   tx_valid_o   byte valid
//   tx_ready_i   transmitter accepts the byte
//   busy_o       drain in progress
//   done_o       one-cycle completion pulse
// -----------------------------------------------------------------------------
module cr_result_reader #(
    parameter int WORD_W = 776,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   n_words_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    input  logic [WORD_W-1:0] ram_dout_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o
);

    localparam int N_BYTES = WORD_W / 8;
    localparam int BC_W    = $clog2(N_BYTES + 1);
    localparam int WC_W    = ADDR_W + 1;
    // RD_LAT must be at least 1: WAIT always lasts one or more cycles.
    localparam int LAT_W   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(N_BYTES - 1);
    localparam logic [LAT_W-1:0] LAST_WAIT = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_WAIT = 3'd2,
        S_LOAD = 3'd3,
        S_SEND = 3'd4,
        S_NEXT = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t             state_r,     state_s;
    logic [ADDR_W-1:0]  base_r,      base_s;
    logic [WC_W-1:0]    n_words_r,   n_words_s;
    logic [WC_W-1:0]    word_cnt_r,  word_cnt_s;
    logic [BC_W-1:0]    byte_cnt_r,  byte_cnt_s;
    logic [LAT_W-1:0]   wait_cnt_r,  wait_cnt_s;
    logic [WORD_W-1:0]  shift_r,     shift_s;
    logic [ADDR_W-1:0]  ram_addr_r,  ram_addr_s;
    logic               tx_valid_r,  tx_valid_s;
    logic               busy_r,      busy_s;
    logic               done_r,      done_s;
    logic               accept_s;

    // A byte is transferred only when it is actually being offered.
    assign accept_s = tx_valid_r & tx_ready_i;

    assign ram_addr_o = ram_addr_r;
    assign tx_data_o  = shift_r[WORD_W-1 -: 8];
    assign tx_valid_o = tx_valid_r;
    assign busy_o     = busy_r;
    assign done_o     = done_r;

    // Next-state and next-output computation for the drain FSM.
    always_comb begin
        state_s    = state_r;
        base_s     = base_r;
        n_words_s  = n_words_r;
        word_cnt_s = word_cnt_r;
        byte_cnt_s = byte_cnt_r;
        wait_cnt_s = wait_cnt_r;
        shift_s    = shift_r;
        ram_addr_s = ram_addr_r;
        tx_valid_s = tx_valid_r;
        busy_s     = busy_r;
        done_s     = 1'b0;

        case (state_r)
            S_IDLE: begin
                if (start_i) begin
                    base_s     = base_addr_i;
                    n_words_s  = n_words_i;
                    word_cnt_s = {WC_W{1'b0}};
                    busy_s     = 1'b1;
                    if (n_words_i == {WC_W{1'b0}}) begin
                        state_s = S_DONE;
                    end else begin
                        state_s = S_ADDR;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_ADDR: begin
                // Sum is truncated to ADDR_W bits so the address wraps.
                ram_addr_s = base_r + word_cnt_r[ADDR_W-1:0];
                wait_cnt_s = {LAT_W{1'b0}};
                state_s    = S_WAIT;
            end

            S_WAIT: begin
                // The address register is visible in the first WAIT cycle,
                // so RD_LAT cycles here put valid data on ram_dout_i in LOAD.
                if (wait_cnt_r == LAST_WAIT) begin
                    state_s = S_LOAD;
                end else begin
                    wait_cnt_s = wait_cnt_r + LAT_W'(1);
                end
            end

            S_LOAD: begin
                shift_s    = ram_dout_i;
                byte_cnt_s = {BC_W{1'b0}};
                tx_valid_s = 1'b1;
                state_s    = S_SEND;
            end

            S_SEND: begin
                if (accept_s) begin
                    shift_s    = {shift_r[WORD_W-9:0], 8'h00};
                    byte_cnt_s = byte_cnt_r + BC_W'(1);
                    if (byte_cnt_r == LAST_BYTE) begin
                        tx_valid_s = 1'b0;
                        state_s    = S_NEXT;
                    end else begin
                        state_s    = S_SEND;
                    end
                end else begin
                    // Stalled: data and valid are held by the defaults.
                    state_s = S_SEND;
                end
            end

            S_NEXT: begin
                word_cnt_s = word_cnt_r + WC_W'(1);
                if ((word_cnt_r + WC_W'(1)) == n_words_r) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_ADDR;
                end
            end

            S_DONE: begin
                // Registered: done_o rises and busy_o falls together next cycle.
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = S_IDLE;
            end

            default: begin
                tx_valid_s = 1'b0;
                busy_s     = 1'b0;
                state_s    = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            base_r     <= {ADDR_W{1'b0}};
            n_words_r  <= {WC_W{1'b0}};
            word_cnt_r <= {WC_W{1'b0}};
            byte_cnt_r <= {BC_W{1'b0}};
            wait_cnt_r <= {LAT_W{1'b0}};
            shift_r    <= {WORD_W{1'b0}};
            ram_addr_r <= {ADDR_W{1'b0}};
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            base_r     <= base_s;
            n_words_r  <= n_words_s;
            word_cnt_r <= word_cnt_s;
            byte_cnt_r <= byte_cnt_s;
            wait_cnt_r <= wait_cnt_s;
            shift_r    <= shift_s;
            ram_addr_r <= ram_addr_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
        end
    end

endmodule
